fp_mul_iter: RTL and testbench

Parametrised, multi-cycle IEEE-754 floating-point multiplier for single (N=32) or double (N=64) precision. It computes the significand product with an iterative radix-2^R shift-add datapath and applies correct special-case handling, overflow to infinity, and round-to-nearest-even. It uses valid/ready handshakes on both sides, so it can sit between operand-issue logic and the result writeback in the FPU datapath.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp_mant_mul_iter.sv | 62 ++++++
 rtl/fp_mul_iter.sv | 172 +++++++++++++++++
 tb/tb_fp_mul_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, format helpers, FSM states and flag indices for fp_mul_iter
package fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } fp_state_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_m(input int n);
    return (n == 64) ? 52 : 23;
  endfunction

  function automatic int fp_e(input int n);
    return (n == 64) ? 11 : 8;
  endfunction

  function automatic int fp_bias(input int n);
    return (n == 64) ? 1023 : 127;
  endfunction

  // Encodings are returned 64 bits wide; callers size-cast to their own width.
  function automatic logic [63:0] fp_nan(input int n);
    if (n == 64) return 64'h7FFF_FFFF_FFFF_FFFF;
    return 64'h0000_0000_7FFF_FFFF;
  endfunction

  function automatic logic [63:0] fp_inf(input int n, input logic s);
    if (n == 64) return {s, 11'h7FF, 52'h0};
    return {32'h0, s, 8'hFF, 23'h0};
  endfunction

  function automatic logic [63:0] fp_zero(input int n, input logic s);
    if (n == 64) return {s, 63'h0};
    return {32'h0, s, 31'h0};
  endfunction

endpackage

// File: rtl/fp_mant_mul_iter.sv
// rtl/fp_mant_mul_iter.sv - shift-add significand multiplier consuming R multiplier bits per cycle
module fp_mant_mul_iter #(
  parameter int MW = 24,
  parameter int R  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MW-1:0]   a,
  input  logic [MW-1:0]   b,
  output logic            done,
  output logic [2*MW-1:0] product
);

  localparam int ITER = (MW + R - 1) / R;
  localparam int PW   = 2 * MW;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [PW-1:0] mcand_q;
  logic [MW-1:0] mplier_q;
  logic [PW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [PW-1:0] partial;

  // Partial product of the low R multiplier bits against the shifted multiplicand.
  always_comb begin
    partial = '0;
    for (int j = 0; j < R; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // Load on start, then accumulate one R-bit digit per cycle for ITER cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{MW{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_q + partial;
      mcand_q  <= mcand_q << R;
      mplier_q <= mplier_q >> R;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  // done is high during the final accumulation cycle so the caller can step on the same edge.
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_q;

endmodule

// File: rtl/fp_mul_iter.sv
// rtl/fp_mul_iter.sv - iterative IEEE-754 multiplier; FP_MUL_ROUND_EN selects round-to-nearest-even, else truncation
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int N = 32,
  parameter int R = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic [3:0]   flags
);

  localparam int M    = fp_m(N);
  localparam int E    = fp_e(N);
  localparam int BIAS = fp_bias(N);
  localparam int MW   = M + 1;
  localparam int PW   = 2 * MW;
  localparam logic signed [E+1:0] BIAS_X  = (E+2)'(BIAS);
  localparam logic signed [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);

  fp_state_e state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         sign_q;
  logic [E-1:0] ea_q, eb_q;

  logic         sa, sb;
  logic [E-1:0] ea, eb;
  logic [M-1:0] ma, mb;
  logic         a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic         special, accept, start, mul_done;
  logic [PW-1:0] prod;

  assign {sa, ea, ma} = A;
  assign {sb, eb, mb} = B;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (&ea) && (ma == '0);
  assign b_inf   = (&eb) && (mb == '0);
  assign a_nan   = (&ea) && (ma != '0);
  assign b_nan   = (&eb) && (mb != '0);
  assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
  assign accept  = in_valid && in_ready;
  assign start   = accept && !special;

  fp_mant_mul_iter #(.MW(MW), .R(R)) u_mant (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       ({1'b1, ma}),
    .b       ({1'b1, mb}),
    .done    (mul_done),
    .product (prod)
  );

  logic [N-1:0] spec_res;
  logic [3:0]   spec_flags;

  // Special operands resolve straight from the inputs: NaN first, then Inf, then zero.
  always_comb begin
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      spec_res = N'(fp_nan(N));
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = N'(fp_inf(N, sa ^ sb));
    end else begin
      spec_res = N'(fp_zero(N, sa ^ sb));
    end
  end

  logic [PW-2:0]         norm;
  logic [M-1:0]          frac, frac_r;
  logic                  guard, sticky, round_up, carry;
  logic signed [E+1:0]   exp_raw, exp_fin;
  logic [N-1:0]          norm_res;
  logic [3:0]            norm_flags;

  // Normalise the product, round, and range-check the exponent.
  always_comb begin
    norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    frac   = norm[PW-2:MW];
    guard  = norm[M];
    sticky = |norm[M-1:0];
`ifdef FP_MUL_ROUND_EN
    round_up = guard & (sticky | frac[0]);
`else
    round_up = 1'b0;
`endif
    // A carry leaves frac_r all zeros, which is already the renormalised fraction.
    {carry, frac_r} = {1'b0, frac} + {{M{1'b0}}, round_up};
    exp_raw = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_X
              + $signed({{(E+1){1'b0}}, prod[PW-1]});
    exp_fin = exp_raw + $signed({{(E+1){1'b0}}, carry});
    norm_flags = '0;
    if (exp_fin >= EXP_MAX) begin
      norm_res = N'(fp_inf(N, sign_q));
      norm_flags[FLAG_OVERFLOW] = 1'b1;
      norm_flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_fin[E+1] || (exp_fin == '0)) begin
      norm_res = N'(fp_zero(N, sign_q));
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
      norm_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      norm_res = {sign_q, exp_fin[E-1:0], frac_r};
      norm_flags[FLAG_INEXACT] = guard | sticky;
    end
  end

  // Next-state and result register loading.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (special) begin
            state_d  = S_DONE;
            result_d = spec_res;
            flags_d  = spec_flags;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL:  if (mul_done) state_d = S_NORM;
      S_NORM: begin
        state_d  = S_DONE;
        result_d = norm_res;
        flags_d  = norm_flags;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, result and captured sign/exponent registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      if (start) begin
        sign_q <= sa ^ sb;
        ea_q   <= ea;
        eb_q   <= eb;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// tb/tb_fp_mul_iter.sv - randomized and directed bench for fp_mul_iter (N=32, R=1)
module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mul_iter #(.N(32), .R(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .flags     (flags)
  );

`ifdef FP_MUL_ROUND_EN
  localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
  localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

  // Reference: exact integer product, then round by comparing the discarded remainder to half an ulp.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] mx, my;
    bit xz, yz, xi, yi, xn, yn, lost;
    logic [63:0] p, kept, rem, half;
    int e, sh;
    s = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    mx = x[22:0];  my = y[22:0];
    xz = (ex == 8'h00); yz = (ey == 8'h00);
    xi = (ex == 8'hFF) && (mx == 0); yi = (ey == 8'hFF) && (my == 0);
    xn = (ex == 8'hFF) && (mx != 0); yn = (ey == 8'hFF) && (my != 0);
    lat = 1;
    f = 4'b0000;
    if (xn || yn || (xz && yi) || (xi && yz)) begin
      r = 32'h7FFF_FFFF;
      f = 4'b1000;
    end else if (xi || yi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (xz || yz) begin
      r = {s, 31'h0};
    end else begin
      lat = 25;
      p = {40'h0, 1'b1, mx} * {40'h0, 1'b1, my};
      e = int'(ex) + int'(ey) - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      else sh = 23;
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      lost = (rem != 0);
`ifdef FP_MUL_ROUND_EN
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
`endif
      if (kept == (64'd1 << 24)) begin kept = 64'd1 << 23; e = e + 1; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0011;
      end else begin
        r = {s, 8'(e), kept[22:0]}; f = {3'b000, lost};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    k = $urandom_range(0, 15);
    s = 1'($urandom);
    m = 23'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) begin e = 8'hFF; m = '0; end
    else if (k == 2) begin e = 8'hFF; m = m | 23'h1; end
    else if (k < 10) e = 8'($urandom_range(64, 190));
    else e = 8'($urandom_range(1, 254));
    return {s, e, m};
  endfunction

  // Issue one operation and wait for out_valid; lat=-1 if it never arrives.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; r = '0; f = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    r = result; f = flags;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", flags); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] xa, xb, r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    v[0] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'h0, 25};
    v[1] = '{32'h0000_0000, 32'h7F80_0000, 32'h7FFF_FFFF, 4'h8, 1};
    v[2] = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FFF_FFFF, 4'h8, 1};
    v[3] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'h5, 25};
    v[4] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'h3, 25};
    v[5] = '{32'h3FC0_0001, 32'h3FC0_0001, RND_EXP,       4'h1, 25};
    v[6] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'h0, 1};
    v[7] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'h0, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].xa, v[i].xb, r, f, lat);
      checks++; if (r !== v[i].r) begin errors++; $display("FAIL directed%0d_result got=%h exp=%h", i, r, v[i].r); end
      checks++; if (f !== v[i].f) begin errors++; $display("FAIL directed%0d_flags got=%h exp=%h", i, f, v[i].f); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [31:0] xa, xb, r, er;
    logic [3:0] f, ef;
    int lat, elat;
    for (int i = 0; i < 150; i++) begin
      xa = rand_op(); xb = rand_op();
      ref_mul(xa, xb, er, ef, elat);
      do_op(xa, xb, r, f, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL random_result %h*%h got=%h exp=%h", xa, xb, r, er); end
      checks++; if (f !== ef) begin errors++; $display("FAIL random_flags %h*%h got=%h exp=%h", xa, xb, f, ef); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL random_latency %h*%h got=%0d exp=%0d", xa, xb, lat, elat); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    logic [3:0] f0;
    int lat;
    do_op(32'h4040_0000, 32'h3F80_0000, r0, f0, lat);
    checks++; if (r0 !== 32'h4040_0000) begin errors++; $display("FAIL bp_result got=%h exp=40400000", r0); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== r0 || flags !== f0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle%0d got=%h/%h/v%b/r%b exp=%h/%h/v1/r0", i, result, flags, out_valid, in_ready, r0, f0);
      end
    end
    handshake();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
    a = 32'h7F80_0000; b = 32'h3F80_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got=v%b/r%b exp=v1/r0", out_valid, in_ready); end
    checks++; if (result !== 32'h7F80_0000) begin errors++; $display("FAIL bp_next_result got=%h exp=7f800000", result); end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    a = 32'h3FC0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (result !== 32'h0 || flags !== 4'h0) begin errors++; $display("FAIL rstmid_outputs got=%h/%h exp=0/0", result, flags); end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'hC000_0000, 32'h4000_0000, r, f, lat);
    checks++; if (r !== 32'hC080_0000) begin errors++; $display("FAIL rstmid_after_result got=%h exp=c0800000", r); end
    checks++; if (f !== 4'h0) begin errors++; $display("FAIL rstmid_after_flags got=%h exp=0", f); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL rstmid_after_latency got=%0d exp=25", lat); end
    handshake();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
